nibble_serial_adder: RTL

//   Sequential wide adder that sums two WIDTH-bit operands one 4-bit nibble per clock.

---
 rtl/nibble_serial_adder.sv | 87 ++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Wide adder that sums two WIDTH-bit operands one 4-bit nibble per clock,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int IDX_W = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, b_r, sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] base;
  logic [4:0]       nib_add;
  logic             last;

  // One 4-bit slice with carry-in; the 5-bit result keeps the nibble carry.
  always_comb begin
    base    = IDX_W'({cnt, 2'b00});
    nib_add = {1'b0, a_r[base +: 4]} + {1'b0, b_r[base +: 4]} + {4'b0000, carry};
    last    = (cnt == CNT_W'(NIB - 1));
  end

  // NOTE: every output of a combinational block is assigned a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= A;
          b_r   <= B;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          sum[base +: 4] <= nib_add[3:0];
          carry          <= nib_add[4];
          cnt            <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result is held in the working registers until the next accept overwrites it.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = {carry, sum};

endmodule
